// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester-side bundle for the register file arbiter
interface regfile_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          a_req, a_rd, a_wr;
    logic [AW-1:0] a_rs1, a_rs2, a_dr;
    logic [DW-1:0] a_wdata;
    logic          b_req, b_rd, b_wr;
    logic [AW-1:0] b_rs1, b_rs2, b_dr;
    logic [DW-1:0] b_wdata;
    logic          a_gnt, b_gnt;
    logic          a_rvalid, b_rvalid;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          init_done;

    modport slave (
        input  a_req, a_rd, a_wr, a_rs1, a_rs2, a_dr, a_wdata,
        input  b_req, b_rd, b_wr, b_rs1, b_rs2, b_dr, b_wdata,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata_a, rdata_b, init_done
    );

    modport master (
        output a_req, a_rd, a_wr, a_rs1, a_rs2, a_dr, a_wdata,
        output b_req, b_rd, b_wr, b_rs1, b_rs2, b_dr, b_wdata,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata_a, rdata_b, init_done
    );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - init sweep plus round-robin arbiter for the register file command port
// Optional: define RF_BYPASS_EN so read-write ops return post-write values.
module regfile_arbiter #(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    regfile_arbiter_if.slave bus,
    output logic          rf_EN,
    output logic          rf_RD,
    output logic          rf_WR,
    output logic [AW-1:0] rf_rs1,
    output logic [AW-1:0] rf_rs2,
    output logic [AW-1:0] rf_DR,
    output logic [DW-1:0] rf_Data_in,
    input  logic [DW-1:0] rf_BusA,
    input  logic [DW-1:0] rf_BusB
);
    typedef enum logic [1:0] {INIT, IDLE, ISSUE, WAIT} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state, stateNext;
    logic [AW-1:0] idx, idxNext;
    logic          lastB, lastBNext;
    logic          owner, ownerNext;
    logic          opRead, opReadNext;
`ifdef RF_BYPASS_EN
    logic          opRw, opRwNext;
`endif
    logic          aGntNext, bGntNext, aValidNext, bValidNext, initDoneNext;
    logic [DW-1:0] rdataANext, rdataBNext, dataNext;
    logic          enNext, rdNext, wrNext;
    logic [AW-1:0] rs1Next, rs2Next, drNext;
    logic          pickA, pickB;

    // lastB set means B was granted most recently, so A wins a tie
    assign pickA = bus.a_req && (!bus.b_req || lastB);
    assign pickB = bus.b_req && !pickA;

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        lastBNext    = lastB;
        ownerNext    = owner;
        opReadNext   = opRead;
`ifdef RF_BYPASS_EN
        opRwNext     = opRw;
`endif
        aGntNext     = 1'b0;
        bGntNext     = 1'b0;
        aValidNext   = 1'b0;
        bValidNext   = 1'b0;
        initDoneNext = bus.init_done;
        rdataANext   = bus.rdata_a;
        rdataBNext   = bus.rdata_b;
        enNext       = 1'b0;
        rdNext       = 1'b0;
        wrNext       = 1'b0;
        rs1Next      = rf_rs1;
        rs2Next      = rf_rs2;
        drNext       = rf_DR;
        dataNext     = rf_Data_in;
        case (state)
            INIT: begin
                enNext   = 1'b1;
                wrNext   = 1'b1;
                drNext   = idx;
                dataNext = '0;
                idxNext  = idx + 1'b1;
                if (idx == LAST) begin
                    initDoneNext = 1'b1;
                    idxNext      = '0;
                    stateNext    = IDLE;
                end
            end
            IDLE: begin
                if (pickA || pickB) begin
                    aGntNext  = pickA;
                    bGntNext  = pickB;
                    lastBNext = pickB;
                    ownerNext = pickB;
                    stateNext = ISSUE;
                    if (pickB) begin
                        enNext   = bus.b_rd | bus.b_wr;
                        rdNext   = bus.b_rd;
                        wrNext   = bus.b_wr;
                        rs1Next  = bus.b_rs1;
                        rs2Next  = bus.b_rs2;
                        drNext   = bus.b_dr;
                        dataNext = bus.b_wdata;
                    end else begin
                        enNext   = bus.a_rd | bus.a_wr;
                        rdNext   = bus.a_rd;
                        wrNext   = bus.a_wr;
                        rs1Next  = bus.a_rs1;
                        rs2Next  = bus.a_rs2;
                        drNext   = bus.a_dr;
                        dataNext = bus.a_wdata;
                    end
                    opReadNext = rdNext;
`ifdef RF_BYPASS_EN
                    opRwNext   = rdNext & wrNext;
`endif
                end
            end
            ISSUE: begin
                stateNext = opRead ? WAIT : IDLE;
            end
            WAIT: begin
`ifdef RF_BYPASS_EN
                // rf_DR and rf_Data_in still hold the op's destination and write data
                rdataANext = (opRw && rf_rs1 == rf_DR) ? rf_Data_in : rf_BusA;
                rdataBNext = (opRw && rf_rs2 == rf_DR) ? rf_Data_in : rf_BusB;
`else
                rdataANext = rf_BusA;
                rdataBNext = rf_BusB;
`endif
                aValidNext = !owner;
                bValidNext = owner;
                stateNext  = IDLE;
            end
            default: stateNext = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= INIT;
            idx           <= '0;
            lastB         <= 1'b1;
            owner         <= 1'b0;
            opRead        <= 1'b0;
`ifdef RF_BYPASS_EN
            opRw          <= 1'b0;
`endif
            bus.a_gnt     <= 1'b0;
            bus.b_gnt     <= 1'b0;
            bus.a_rvalid  <= 1'b0;
            bus.b_rvalid  <= 1'b0;
            bus.rdata_a   <= '0;
            bus.rdata_b   <= '0;
            bus.init_done <= 1'b0;
            rf_EN         <= 1'b0;
            rf_RD         <= 1'b0;
            rf_WR         <= 1'b0;
            rf_rs1        <= '0;
            rf_rs2        <= '0;
            rf_DR         <= '0;
            rf_Data_in    <= '0;
        end else begin
            state         <= stateNext;
            idx           <= idxNext;
            lastB         <= lastBNext;
            owner         <= ownerNext;
            opRead        <= opReadNext;
`ifdef RF_BYPASS_EN
            opRw          <= opRwNext;
`endif
            bus.a_gnt     <= aGntNext;
            bus.b_gnt     <= bGntNext;
            bus.a_rvalid  <= aValidNext;
            bus.b_rvalid  <= bValidNext;
            bus.rdata_a   <= rdataANext;
            bus.rdata_b   <= rdataBNext;
            bus.init_done <= initDoneNext;
            rf_EN         <= enNext;
            rf_RD         <= rdNext;
            rf_WR         <= wrNext;
            rf_rs1        <= rs1Next;
            rf_rs2        <= rs2Next;
            rf_DR         <= drNext;
            rf_Data_in    <= dataNext;
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - randomized self-checking bench for regfile_arbiter
module tb_regfile_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREGS = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    logic          rf_EN, rf_RD, rf_WR;
    logic [AW-1:0] rf_rs1, rf_rs2, rf_DR;
    logic [DW-1:0] rf_Data_in, rf_BusA, rf_BusB;

    regfile_arbiter #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rf_EN      (rf_EN),
        .rf_RD      (rf_RD),
        .rf_WR      (rf_WR),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_DR      (rf_DR),
        .rf_Data_in (rf_Data_in),
        .rf_BusA    (rf_BusA),
        .rf_BusB    (rf_BusB)
    );

    // Register file stub: its reset clears only the lower half, upper half holds junk
    logic [DW-1:0] rfMem [NREGS];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++)
                rfMem[i] <= (i < NREGS / 2) ? '0 : (32'hBAD0_0000 | DW'(i));
            rf_BusA <= '0;
            rf_BusB <= '0;
        end else if (rf_EN) begin
            if (rf_RD) begin
                rf_BusA <= rfMem[rf_rs1];
                rf_BusB <= rfMem[rf_rs2];
            end
            if (rf_WR) rfMem[rf_DR] <= rf_Data_in;
        end
    end

    logic [DW-1:0] expRegs [NREGS];
    logic [DW-1:0] lastRa, lastRb;
    int nChecks = 0;
    int nPass = 0;
    int lastGntWait = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) expRegs[i] = '0;
        lastRa = '0;
        lastRb = '0;
    endtask

    task automatic set_req(input bit isB, input bit req, input bit rd, input bit wr,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] dr, input logic [DW-1:0] wd);
        if (isB) begin
            bus.b_req = req; bus.b_rd = rd; bus.b_wr = wr;
            bus.b_rs1 = rs1; bus.b_rs2 = rs2; bus.b_dr = dr; bus.b_wdata = wd;
        end else begin
            bus.a_req = req; bus.a_rd = rd; bus.a_wr = wr;
            bus.a_rs1 = rs1; bus.a_rs2 = rs2; bus.a_dr = dr; bus.a_wdata = wd;
        end
    endtask

    task automatic wait_gnt(input bit isB, output bit ok);
        ok = 1'b0;
        lastGntWait = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            lastGntWait++;
            if ((isB ? bus.b_gnt : bus.a_gnt) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    task automatic sweep_check(input string tag);
        for (int k = 0; k < NREGS; k++) begin
            tick();
            check({tag, "_en"}, DW'(rf_EN), 1);
            check({tag, "_wr"}, DW'(rf_WR), 1);
            check({tag, "_rd"}, DW'(rf_RD), 0);
            check({tag, "_dr"}, DW'(rf_DR), DW'(k));
            check({tag, "_data"}, rf_Data_in, 0);
            check({tag, "_gnt"}, DW'(bus.a_gnt | bus.b_gnt), 0);
            check({tag, "_rvalid"}, DW'(bus.a_rvalid | bus.b_rvalid), 0);
            check({tag, "_done"}, DW'(bus.init_done), DW'(k == NREGS - 1));
        end
        model_clear();
    endtask

    task automatic do_op(input bit isB, input bit rd, input bit wr,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] dr, input logic [DW-1:0] wd);
        bit ok;
        logic [DW-1:0] eA, eB;
        set_req(isB, 1'b1, rd, wr, rs1, rs2, dr, wd);
        wait_gnt(isB, ok);
        set_req(isB, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        if (ok) begin
            check("other_gnt", DW'(isB ? bus.a_gnt : bus.b_gnt), 0);
            check("rf_en", DW'(rf_EN), DW'(rd | wr));
            check("rf_rd", DW'(rf_RD), DW'(rd));
            check("rf_wr", DW'(rf_WR), DW'(wr));
            check("rf_rs1", DW'(rf_rs1), DW'(rs1));
            check("rf_rs2", DW'(rf_rs2), DW'(rs2));
            check("rf_dr", DW'(rf_DR), DW'(dr));
            check("rf_data", rf_Data_in, wd);
            eA = (BYPASS && rd && wr && rs1 == dr) ? wd : expRegs[rs1];
            eB = (BYPASS && rd && wr && rs2 == dr) ? wd : expRegs[rs2];
            if (wr) expRegs[dr] = wd;
            tick();
            check("gnt_width", DW'(bus.a_gnt | bus.b_gnt), 0);
            check("rf_en_clr", DW'(rf_EN), 0);
            check("rvalid_early", DW'(bus.a_rvalid | bus.b_rvalid), 0);
            tick();
            check("rvalid_mine", DW'(isB ? bus.b_rvalid : bus.a_rvalid), DW'(rd));
            check("rvalid_other", DW'(isB ? bus.a_rvalid : bus.b_rvalid), 0);
            if (rd) begin
                lastRa = eA;
                lastRb = eB;
            end
            check("rdata_a", bus.rdata_a, lastRa);
            check("rdata_b", bus.rdata_b, lastRb);
        end
    endtask

    initial begin
        int gTimes[$];
        bit gWho[$];
        bit ok;
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", DW'(bus.init_done), 0);
        check("reset_en", DW'(rf_EN), 0);
        check("reset_gnt", DW'(bus.a_gnt | bus.b_gnt), 0);
        check("reset_rdata", bus.rdata_a | bus.rdata_b, 0);

        // Sweep with A already requesting; A granted the edge after init_done
        set_req(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 5'd5, 32'hDEAD_BEEF);
        rst = 1'b1;
        sweep_check("sweep");
        do_op(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
        check("first_gnt_lat", DW'(lastGntWait), 1);
        do_op(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, '0);
        check("upper_swept", expRegs[20], 0);
        do_op(1'b1, 1'b1, 1'b0, 5'd20, 5'd31, 5'd0, '0);

        // B granted last, so both held gives A,B,A,B at 2-cycle spacing
        set_req(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 5'd8, 32'hA1A1_A1A1);
        set_req(1'b1, 1'b1, 1'b0, 1'b1, '0, '0, 5'd9, 32'hB1B1_B1B1);
        for (int c = 0; c < 30 && gWho.size() < 4; c++) begin
            tick();
            if (bus.a_gnt && bus.b_gnt) check("dual_gnt", 1, 0);
            if (bus.a_gnt) begin gWho.push_back(1'b0); gTimes.push_back(c); end
            else if (bus.b_gnt) begin gWho.push_back(1'b1); gTimes.push_back(c); end
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        check("rr_count", DW'(gWho.size()), 4);
        for (int i = 0; i < gWho.size(); i++) begin
            check("rr_order", DW'(gWho[i]), DW'(i % 2));
            if (i > 0) check("rr_spacing", DW'(gTimes[i] - gTimes[i-1]), 2);
        end
        expRegs[8] = 32'hA1A1_A1A1;
        expRegs[9] = 32'hB1B1_B1B1;
        tick();
        tick();
        do_op(1'b1, 1'b1, 1'b0, 5'd8, 5'd9, 5'd0, '0);

        // Read-write on one op
        do_op(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11);
        do_op(1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 32'h22);
        check("rw_result", lastRa, BYPASS ? 32'h22 : 32'h11);
        do_op(1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, '0);
        check("rw_after", lastRa, 32'h22);

        // Reset during WAIT abandons the read
        set_req(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd8, '0, '0);
        wait_gnt(1'b0, ok);
        set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_rvalid", DW'(bus.a_rvalid), 0);
        check("rst_done", DW'(bus.init_done), 0);
        tick();
        tick();
        check("rst_rvalid_hold", DW'(bus.a_rvalid), 0);
        check("rst_gnt", DW'(bus.a_gnt), 0);
        rst = 1'b1;
        sweep_check("resweep");

        // First tie after reset goes to A
        set_req(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 5'd3, 32'h3333_0000);
        set_req(1'b1, 1'b1, 1'b0, 1'b1, '0, '0, 5'd4, 32'h4444_0000);
        wait_gnt(1'b0, ok);
        check("tie_a_lat", DW'(lastGntWait), 1);
        check("tie_b_gnt", DW'(bus.b_gnt), 0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        wait_gnt(1'b1, ok);
        check("tie_b_lat", DW'(lastGntWait), 2);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        expRegs[3] = 32'h3333_0000;
        expRegs[4] = 32'h4444_0000;
        tick();
        tick();

        // B alone with back-to-back reads: grant every 3 cycles
        set_req(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd4, '0, '0);
        wait_gnt(1'b1, ok);
        for (int r = 0; r < 3; r++) begin
            tick();
            check("b_rd_gap", DW'(bus.b_gnt), 0);
            if (r == 2) set_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            tick();
            check("b_rd_rvalid", DW'(bus.b_rvalid), 1);
            check("b_rd_a_rvalid", DW'(bus.a_rvalid), 0);
            check("b_rd_data_a", bus.rdata_a, expRegs[3]);
            check("b_rd_data_b", bus.rdata_b, expRegs[4]);
            if (r < 2) begin
                tick();
                check("b_rd_next_gnt", DW'(bus.b_gnt), 1);
            end
        end
        lastRa = expRegs[3];
        lastRb = expRegs[4];

        for (int n = 0; n < 60; n++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)),
                  AW'($urandom_range(0, NREGS - 1)), DW'($urandom));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
